// File: rtl/tff_pkg.sv
// Purpose : shared mode encodings for the T flip-flop counter bank.
// Contents: mode_e enum (TOGGLE/UP/DOWN/LOAD) used by the interface, top and bench.
// Latency : n/a (types only). Backpressure: n/a.
package tff_pkg;

   typedef enum logic [1:0] {
      MODE_TOGGLE = 2'b00,
      MODE_UP     = 2'b01,
      MODE_DOWN   = 2'b10,
      MODE_LOAD   = 2'b11
   } mode_e;

endpackage : tff_pkg

// File: rtl/tff_counter_bank_if.sv
// Purpose : control/status bundle of the T flip-flop counter bank.
// Ports   : master drives en/mode/T/load_val and observes Q/tc/ovf; slave is the bank.
// Latency : n/a (wires only). Backpressure: none, the bank accepts every enabled edge.
interface tff_counter_bank_if #(
   parameter int WIDTH = 4
);
   import tff_pkg::*;

   logic             en;        // update enable
   mode_e            mode;      // operating mode
   logic [WIDTH-1:0] T;         // per-bit toggle request (TOGGLE mode only)
   logic [WIDTH-1:0] load_val;  // parallel load data (LOAD mode only)
   logic [WIDTH-1:0] Q;         // flip-flop bank state
   logic             tc;        // terminal count, combinational
   logic             ovf;       // registered limit pulse

   modport master (
      output en, mode, T, load_val,
      input  Q, tc, ovf
   );

   modport slave (
      input  en, mode, T, load_val,
      output Q, tc, ovf
   );

endinterface : tff_counter_bank_if

// File: rtl/tff_cell.sv
// Purpose : one T flip-flop with synchronous reset and a parallel-load override.
// Ports   : clk, rst (sync, active-high), t_i toggle, load_i/load_d_i load, q_o state.
// Latency : one edge from inputs to q_o. Backpressure: none.
module tff_cell #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic t_i,
   input  logic load_i,
   input  logic load_d_i,
   output logic q_o
);

   logic q_q;
   logic q_d;

   // Load beats toggle; the top never asserts both, but the order is fixed here.
   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = load_d_i;
      end else if (t_i) begin
         q_d = ~q_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule : tff_cell

// File: rtl/tff_counter_bank.sv
// Purpose : WIDTH-bit bank of T flip-flops: per-bit toggle, up/down count or parallel load.
// Ports   : clk, rst (sync, active-high), bus (slave modport: en/mode/T/load_val in, Q/tc/ovf out).
// Latency : Q and ovf update one edge after inputs are sampled; tc is combinational from Q/mode.
// Backpressure: none; en=0 simply holds Q and clears ovf.
module tff_counter_bank
   import tff_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               SATURATE  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   tff_counter_bank_if.slave    bus
);

   logic [WIDTH-1:0] q_w;        // current bank state from the cells
   logic [WIDTH-1:0] up_t;       // carry chain: bit i toggles when all lower bits are 1
   logic [WIDTH-1:0] dn_t;       // borrow chain: bit i toggles when all lower bits are 0
   logic [WIDTH-1:0] tgl_vec;    // per-cell toggle request
   logic             load_w;
   logic             at_limit;   // counting mode is sitting on its limit value
   logic             ovf_q;
   logic             ovf_d;

   // Ripple toggle chains instead of an adder: Q ^ up_t is Q+1, Q ^ dn_t is Q-1.
   always_comb begin
      up_t    = '0;
      dn_t    = '0;
      up_t[0] = 1'b1;
      dn_t[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         up_t[i] = up_t[i-1] &  q_w[i-1];
         dn_t[i] = dn_t[i-1] & ~q_w[i-1];
      end
   end

   always_comb begin
      at_limit = 1'b0;
      if (bus.mode == MODE_UP) begin
         at_limit = &q_w;
      end else if (bus.mode == MODE_DOWN) begin
         at_limit = ~|q_w;
      end
   end

   always_comb begin
      tgl_vec = '0;
      load_w  = 1'b0;
      ovf_d   = 1'b0;
      if (bus.en) begin
         unique case (bus.mode)
            MODE_TOGGLE: tgl_vec = bus.T;
            MODE_UP:     tgl_vec = up_t;
            MODE_DOWN:   tgl_vec = dn_t;
            MODE_LOAD:   load_w  = 1'b1;
            default:     tgl_vec = '0;
         endcase
         ovf_d = at_limit;
         // A saturating counter freezes on its limit but still reports the attempt.
         if ((SATURATE != 0) && at_limit) begin
            tgl_vec = '0;
         end
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      tff_cell #(
         .RST_VAL (RESET_VAL[g])
      ) u_cell (
         .clk      (clk),
         .rst      (rst),
         .t_i      (tgl_vec[g]),
         .load_i   (load_w),
         .load_d_i (bus.load_val[g]),
         .q_o      (q_w[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   // tc depends only on Q and mode, never on en, T or load_val.
   assign bus.Q   = q_w;
   assign bus.tc  = at_limit;
   assign bus.ovf = ovf_q;

endmodule : tff_counter_bank
